mont_adder_seq: RTL and testbench

- Sequencer for the 512-bit carry-save Montgomery adder datapath. Drives one full modular multiplication:
  - 128 radix-16 accumulate/shift iterations;
  - a 6-phase carry-propagate resolve;
  - repeated 6-phase conditional-subtract passes until the datapath reports completion.
- Owns operand-digit scanning, quotient-digit computation and the phase/subtract/shift control lines.

---
 rtl/mont_seq_pkg.sv | 21 ++
 rtl/mont_qdigit.sv | 11 +
 rtl/mont_adder_seq.sv | 168 ++++++++++++++++
 tb/tb_mont_adder_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mont_seq_pkg.sv
// Shared types and constants for the Montgomery adder sequencer.
// Phase code 8 holds the adder's resolve pipeline; codes 0..5 step it.
package mont_seq_pkg;

    localparam int DIGIT_BITS = 4;

    localparam logic [3:0] PHASE_HOLD = 4'd8;
    localparam logic [3:0] PHASE_LAST = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIGIT,
        QCALC,
        SHIFT,
        ADD,
        SUB,
        DONE
    } seq_state_e;

endpackage

// File: rtl/mont_qdigit.sv
// Montgomery quotient digit: (c_bits * m_prime) mod 16.
// A 4-bit result keeps only the low nibble of the product, which is the mod 16.
module mont_qdigit (
    input  logic [3:0] c_bits,
    input  logic [3:0] m_prime,
    output logic [3:0] q_digit
);

    assign q_digit = c_bits * m_prime;

endmodule

// File: rtl/mont_adder_seq.sv
// Sequencer for the carry-save Montgomery adder: radix-16 accumulate/shift
// iterations, a carry-propagate resolve, then conditional-subtract passes.
//
// state | meaning
// IDLE  | waiting for start; operands latched when it arrives
// LOAD  | clear iteration and pass counters
// DIGIT | present next multiplier digit, clear quotient digit
// QCALC | adder shows low accumulator digit; quotient digit captured
// SHIFT | accumulate-and-shift strobe, advance operand scan
// ADD   | resolve phases 0..5 in add mode
// SUB   | resolve phases 0..5 in subtract mode, repeated until finished
// DONE  | one-cycle completion pulse
module mont_adder_seq
    import mont_seq_pkg::*;
#(
    parameter int N_BITS         = 512,
    parameter int MAX_SUB_PASSES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N_BITS-1:0] a_in,
    input  logic [3:0]        m_prime,
    input  logic [3:0]        c_bits,
    input  logic              subtract_finished,
    output logic [3:0]        a_digit,
    output logic [3:0]        q_digit,
    output logic              c_doubleshift,
    output logic [3:0]        phase,
    output logic              subtract,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int ITERS = N_BITS / DIGIT_BITS;
    localparam int IW    = $clog2(ITERS) + 1;
    localparam int PW    = $clog2(MAX_SUB_PASSES) + 1;

    seq_state_e        state_q, state_d;
    logic [N_BITS-1:0] a_sr_q, a_sr_d;
    logic [3:0]        mp_q, mp_d;
    logic [3:0]        a_digit_q, a_digit_d;
    logic [3:0]        q_digit_q, q_digit_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [PW-1:0]     pass_q, pass_d;
    logic [3:0]        phase_q, phase_d;
    logic              err_q, err_d;
    logic [3:0]        q_calc;

    mont_qdigit u_qdigit (
        .c_bits  (c_bits),
        .m_prime (mp_q),
        .q_digit (q_calc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            mp_q      <= '0;
            a_digit_q <= '0;
            q_digit_q <= '0;
            iter_q    <= '0;
            pass_q    <= '0;
            phase_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            mp_q      <= mp_d;
            a_digit_q <= a_digit_d;
            q_digit_q <= q_digit_d;
            iter_q    <= iter_d;
            pass_q    <= pass_d;
            phase_q   <= phase_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        mp_d      = mp_q;
        a_digit_d = a_digit_q;
        q_digit_d = q_digit_q;
        iter_d    = iter_q;
        pass_d    = pass_q;
        phase_d   = phase_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    a_sr_d  = a_in;
                    mp_d    = m_prime;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                iter_d  = '0;
                pass_d  = '0;
                phase_d = '0;
                state_d = DIGIT;
            end
            DIGIT: begin
                a_digit_d = a_sr_q[DIGIT_BITS-1:0];
                q_digit_d = '0;
                state_d   = QCALC;
            end
            QCALC: begin
                q_digit_d = q_calc;
                state_d   = SHIFT;
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> DIGIT_BITS;
                iter_d = iter_q + IW'(1);
                if (iter_q == IW'(ITERS - 1)) begin
                    a_digit_d = '0;
                    q_digit_d = '0;
                    phase_d   = '0;
                    state_d   = ADD;
                end else begin
                    state_d = DIGIT;
                end
            end
            ADD: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    state_d = SUB;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            SUB: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    pass_d  = pass_q + PW'(1);
                    if (subtract_finished) begin
                        state_d = DONE;
                    end else if (pass_q + PW'(1) == PW'(MAX_SUB_PASSES)) begin
                        // Datapath never converged: give up and flag it.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a_digit       = a_digit_q;
    assign q_digit       = q_digit_q;
    assign c_doubleshift = (state_q == SHIFT);
    assign subtract      = (state_q == SUB);
    assign phase         = (state_q == ADD || state_q == SUB) ? phase_q : PHASE_HOLD;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign err           = err_q;

endmodule

// File: tb/tb_mont_adder_seq.sv
// Self-checking bench for mont_adder_seq: a timeline model predicts every
// output cycle by cycle from the operation's schedule and operand values.
module tb_mont_adder_seq;

    localparam int ITERS   = 128;
    localparam int ADD_BEG = 2 + 3 * ITERS;
    localparam int SUB_BEG = ADD_BEG + 6;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [511:0] a_in;
    logic [3:0]   m_prime;
    logic [3:0]   c_bits;
    logic         subtract_finished;
    logic [3:0]   a_digit;
    logic [3:0]   q_digit;
    logic         c_doubleshift;
    logic [3:0]   phase;
    logic         subtract;
    logic         busy;
    logic         done;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    mont_adder_seq dut (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start),
        .a_in              (a_in),
        .m_prime           (m_prime),
        .c_bits            (c_bits),
        .subtract_finished (subtract_finished),
        .a_digit           (a_digit),
        .q_digit           (q_digit),
        .c_doubleshift     (c_doubleshift),
        .phase             (phase),
        .subtract          (subtract),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] a;
        logic [3:0]   m;
        int           c_fixed;
        int           fin_pass;
        bit           spurious;
        int           exp_done;
        bit           exp_err;
    } vec_t;

    task automatic chk(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int n, input bit e_err);
        chk({tag, ".a_digit"}, n, {4'b0, a_digit}, 8'h0);
        chk({tag, ".q_digit"}, n, {4'b0, q_digit}, 8'h0);
        chk({tag, ".c_dshift"}, n, {7'b0, c_doubleshift}, 8'h0);
        chk({tag, ".phase"}, n, {4'b0, phase}, 8'h8);
        chk({tag, ".subtract"}, n, {7'b0, subtract}, 8'h0);
        chk({tag, ".busy"}, n, {7'b0, busy}, 8'h0);
        chk({tag, ".done"}, n, {7'b0, done}, 8'h0);
        chk({tag, ".err"}, n, {7'b0, err}, {7'b0, e_err});
    endtask

    function automatic logic [511:0] rand_a();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Cycle n counts clock periods after the accepting edge: LOAD is cycle 1.
    task automatic run_op(input logic [511:0] a, input logic [3:0] m, input int c_fixed,
                          input int fin_pass, input bit spurious, input int exp_done,
                          input bit exp_err, input int busy_start_cyc, input int abort_cyc);
        logic [3:0]   qv [0:ITERS-1];
        logic [511:0] sh;
        logic [3:0]   e_a, e_q, e_ph, dig, c_now;
        logic         e_cds, e_sub, e_busy, e_done, e_err;
        int           i, slot, p, pass, cds_cnt;
        cds_cnt = 0;
        a_in    = a;
        m_prime = m;
        start   = 1'b1;
        for (int n = 1; n <= exp_done + 2; n++) begin
            @(negedge clk);
            e_a = 4'h0; e_q = 4'h0; e_cds = 1'b0; e_ph = 4'h8; e_sub = 1'b0;
            e_busy = (n < exp_done);
            e_done = (n == exp_done);
            e_err  = (n >= exp_done) ? exp_err : 1'b0;
            i = 0; slot = 0;
            if (n >= 2 && n < ADD_BEG) begin
                i    = (n - 2) / 3;
                slot = (n - 2) % 3;
                sh   = a >> (4 * i);
                dig  = sh[3:0];
                if (slot == 0) begin
                    if (i > 0) begin
                        sh  = a >> (4 * (i - 1));
                        e_a = sh[3:0];
                        e_q = qv[i-1];
                    end
                end else begin
                    e_a = dig;
                    if (slot == 2) begin
                        e_q   = qv[i];
                        e_cds = 1'b1;
                    end
                end
            end else if (n >= ADD_BEG && n < SUB_BEG) begin
                e_ph = 4'(n - ADD_BEG);
            end else if (n >= SUB_BEG && n < exp_done) begin
                e_ph  = 4'((n - SUB_BEG) % 6);
                e_sub = 1'b1;
            end
            chk("a_digit", n, {4'b0, a_digit}, {4'b0, e_a});
            chk("q_digit", n, {4'b0, q_digit}, {4'b0, e_q});
            chk("c_dshift", n, {7'b0, c_doubleshift}, {7'b0, e_cds});
            chk("phase", n, {4'b0, phase}, {4'b0, e_ph});
            chk("subtract", n, {7'b0, subtract}, {7'b0, e_sub});
            chk("busy", n, {7'b0, busy}, {7'b0, e_busy});
            chk("done", n, {7'b0, done}, {7'b0, e_done});
            chk("err", n, {7'b0, err}, {7'b0, e_err});
            if (c_doubleshift) cds_cnt++;
            if (n == abort_cyc) begin
                resetn = 1'b0;
                start  = 1'b0;
                #1;
                chk_idle("abort", n, 1'b0);
                @(negedge clk);
                chk_idle("abort_hold", n + 1, 1'b0);
                resetn = 1'b1;
                return;
            end
            // Drive inputs seen by the edge that closes cycle n.
            start = (n == busy_start_cyc);
            if (n == 1 || n == busy_start_cyc) a_in = rand_a();
            c_now  = (c_fixed >= 0) ? 4'(c_fixed) : 4'($urandom);
            c_bits = c_now;
            if (n >= 2 && n < ADD_BEG && slot == 1) qv[i] = 4'((int'(c_now) * int'(m)) % 16);
            if (n >= SUB_BEG && n < exp_done) begin
                p    = (n - SUB_BEG) % 6;
                pass = (n - SUB_BEG) / 6 + 1;
                if (p == 5) subtract_finished = (pass == fin_pass);
                else subtract_finished = spurious && (p == 2 || p == 3 || $urandom_range(1, 0) == 1);
            end else begin
                subtract_finished = spurious && ($urandom_range(1, 0) == 1);
            end
        end
        chk("dshift_count", exp_done, 8'(cds_cnt), 8'(ITERS));
        subtract_finished = 1'b0;
    endtask

    vec_t vecs [0:4];
    int   k, fin, e_done;
    logic [511:0] ra;
    logic [3:0]   rm;

    initial begin
        vecs[0] = '{a: 512'h321, m: 4'hF, c_fixed: 3, fin_pass: 1, spurious: 1'b0, exp_done: 398, exp_err: 1'b0};
        vecs[1] = '{a: rand_a(), m: 4'h7, c_fixed: -1, fin_pass: 3, spurious: 1'b1, exp_done: 410, exp_err: 1'b0};
        vecs[2] = '{a: rand_a(), m: 4'h9, c_fixed: -1, fin_pass: 0, spurious: 1'b0, exp_done: 416, exp_err: 1'b1};
        vecs[3] = '{a: rand_a(), m: 4'hB, c_fixed: -1, fin_pass: 2, spurious: 1'b0, exp_done: 404, exp_err: 1'b0};
        vecs[4] = '{a: rand_a(), m: 4'h5, c_fixed: -1, fin_pass: 4, spurious: 1'b1, exp_done: 416, exp_err: 1'b0};

        resetn = 1'b0; start = 1'b0; a_in = '0; m_prime = 4'h0;
        c_bits = 4'h0; subtract_finished = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk_idle("in_reset", n, 1'b0);
        end
        resetn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk_idle("idle", n, 1'b0);
        end

        for (int v = 0; v < 5; v++)
            run_op(vecs[v].a, vecs[v].m, vecs[v].c_fixed, vecs[v].fin_pass, vecs[v].spurious,
                   vecs[v].exp_done, vecs[v].exp_err, -1, -1);

        for (int r = 0; r < 3; r++) begin
            ra  = rand_a();
            rm  = 4'($urandom);
            fin = $urandom_range(4, 0);
            k   = (fin == 0) ? 4 : fin;
            e_done = 1 + 3 * ITERS + 6 + 6 * k + 1;
            run_op(ra, rm, -1, fin, 1'($urandom), e_done, fin == 0, -1, -1);
        end

        // Start while busy is ignored, then reset lands in iteration 50.
        run_op(rand_a(), 4'h3, -1, 1, 1'b0, 398, 1'b0, 20, 2 + 3 * 50);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk_idle("post_abort", n, 1'b0);
        end
        run_op(rand_a(), 4'hD, -1, 1, 1'b0, 398, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
